// File: rtl/arith_seq_unit_if.sv
// Operand/result bundle for arith_seq_unit: valid/ready on the operand side and on the result side.
// The master drives operands and result acceptance; the slave returns results and flags.
interface arith_seq_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             div_zero;
    logic             illegal_op;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, carry, div_zero, illegal_op
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, carry, div_zero, illegal_op
    );
endinterface

// File: rtl/arith_seq_unit.sv
// Sequential ADD/SUB/MUL/DIV/MOD unit; 1 cycle for add/sub/illegal/div-by-zero, WIDTH+1 for mul/div/mod.
// One op in flight; DONE holds results stable until out_ready, in_ready only in IDLE.
module arith_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    arith_seq_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             carry_q, carry_d;
    logic             div_zero_q, div_zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH:0]   addsub;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] rem_n, quo_n;

    // hi/lo hold {product high, multiplier->product low} for MUL and {remainder, dividend->quotient} for DIV/MOD
    always_comb begin
        addsub    = (bus.op == OP_SUB) ? ({1'b0, bus.a} - {1'b0, bus.b})
                                       : ({1'b0, bus.a} + {1'b0, bus.b});
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // The running remainder is below the divisor, so a set top bit means the trial went negative
        rem_n     = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        quo_n     = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        res_d      = res_q;
        res_hi_d   = res_hi_q;
        carry_d    = carry_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d       = bus.op;
                    hi_d       = '0;
                    cnt_d      = '0;
                    res_d      = '0;
                    res_hi_d   = '0;
                    carry_d    = 1'b0;
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                    state_d    = DONE;
                    case (bus.op)
                        OP_ADD, OP_SUB: begin
                            res_d   = addsub[WIDTH-1:0];
                            carry_d = addsub[WIDTH];
                        end
                        OP_MUL: begin
                            opnd_d  = bus.a;
                            lo_d    = bus.b;
                            cnt_d   = CW'(WIDTH - 1);
                            state_d = CALC;
                        end
                        OP_DIV, OP_MOD: begin
                            if (bus.b == '0) begin
                                div_zero_d = 1'b1;
                                res_d      = (bus.op == OP_DIV) ? {WIDTH{1'b1}} : bus.a;
                            end else begin
                                opnd_d  = bus.b;
                                lo_d    = bus.a;
                                cnt_d   = CW'(WIDTH - 1);
                                state_d = CALC;
                            end
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            CALC: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_hi_n;
                    lo_d = mul_lo_n;
                end else begin
                    hi_d = rem_n;
                    lo_d = quo_n;
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (op_q == OP_MUL) begin
                        res_d    = mul_lo_n;
                        res_hi_d = mul_hi_n;
                    end else begin
                        res_d    = (op_q == OP_DIV) ? quo_n : rem_n;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            res_q      <= '0;
            res_hi_q   <= '0;
            carry_q    <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            res_q      <= res_d;
            res_hi_q   <= res_hi_d;
            carry_q    <= carry_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.result     = res_q;
    assign bus.result_hi  = res_hi_q;
    assign bus.carry      = carry_q;
    assign bus.div_zero   = div_zero_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed bench for arith_seq_unit (WIDTH=8) with hand-computed expected results and latencies.
module tb_arith_seq_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    arith_seq_unit_if #(.WIDTH(8)) bus ();
    arith_seq_unit #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issue one op, measure edges until out_valid, check outputs, optionally stall, then accept.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] exp_res, input logic [7:0] exp_hi,
                          input logic exp_c, input logic exp_dz, input logic exp_ill, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " in_ready_before"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.op = 3'($urandom);
        lat = 1;
        check({tag, " in_ready_after_accept"}, 32'(bus.in_ready), 0);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(bus.result), 32'(exp_res));
        check({tag, " result_hi"}, 32'(bus.result_hi), 32'(exp_hi));
        check({tag, " carry"}, 32'(bus.carry), 32'(exp_c));
        check({tag, " div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
        check({tag, " illegal_op"}, 32'(bus.illegal_op), 32'(exp_ill));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(bus.out_valid), 1);
            check({tag, " hold_result"}, 32'(bus.result), 32'(exp_res));
            check({tag, " hold_carry"}, 32'(bus.carry), 32'(exp_c));
            check({tag, " hold_in_ready"}, 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " out_valid_after_accept"}, 32'(bus.out_valid), 0);
        check({tag, " in_ready_after_result"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 1);
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst result", 32'(bus.result), 0);
        check("rst result_hi", 32'(bus.result_hi), 0);
        check("rst flags", 32'({bus.carry, bus.div_zero, bus.illegal_op}), 0);
        rst_n = 1'b1;

        //      tag          op    a    b   lat  res  hi   c  dz ill hold
        run_op("add10_3",   3'd0, 10,   3,  1,  13,   0, 0, 0, 0, 5);
        run_op("sub3_10",   3'd1,  3,  10,  1, 249,   0, 1, 0, 0, 0);
        run_op("add200_100",3'd0, 200, 100, 1,  44,   0, 1, 0, 0, 0);
        run_op("sub10_3",   3'd1, 10,   3,  1,   7,   0, 0, 0, 0, 0);
        run_op("mul10_3",   3'd2, 10,   3,  9,  30,   0, 0, 0, 0, 0);
        run_op("mul200_200",3'd2, 200, 200, 9, 8'h40, 8'h9C, 0, 0, 0, 2);
        run_op("mul255_255",3'd2, 255, 255, 9,   1, 254, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++)
            run_op("mul_loop", 3'd2, 10, 8'(k), 9, 8'(10 * k), 0, 0, 0, 0, 0);
        run_op("div10_3",   3'd3, 10,   3,  9,   3,   0, 0, 0, 0, 0);
        run_op("mod10_3",   3'd4, 10,   3,  9,   1,   0, 0, 0, 0, 0);
        run_op("div200_7",  3'd3, 200,  7,  9,  28,   0, 0, 0, 0, 0);
        run_op("mod200_7",  3'd4, 200,  7,  9,   4,   0, 0, 0, 0, 0);
        run_op("div255_1",  3'd3, 255,  1,  9, 255,   0, 0, 0, 0, 0);
        run_op("mod7_9",    3'd4,  7,   9,  9,   7,   0, 0, 0, 0, 0);
        run_op("div10_0",   3'd3, 10,   0,  1, 255,   0, 0, 1, 0, 0);
        run_op("mod10_0",   3'd4, 10,   0,  1,  10,   0, 0, 1, 0, 0);
        run_op("op6",       3'd6, 10,   3,  1,   0,   0, 0, 0, 1, 0);
        run_op("add_after_ill", 3'd0, 5, 6, 1,  11,   0, 0, 0, 0, 0);

        // Reset during MUL CALC discards the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 3'd2;
        bus.a = 8'd9;
        bus.b = 8'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst pre out_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst in_ready", 32'(bus.in_ready), 1);
        check("mid_rst result", 32'(bus.result), 0);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("mid_rst no out_valid", 32'(seen), 0);
        end
        check("mid_rst in_ready after", 32'(bus.in_ready), 1);
        run_op("add1_1",    3'd0,  1,   1,  1,   2,   0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
